// File: rtl/strobed_integrate_dump.sv
// Integrate-and-dump decimator: sums L strobed signed samples, dumps (sum >>> shift) clipped to WIDTH.
// Dump is registered on the edge sampling the block's last strobe; no backpressure, full throughput.
module strobed_integrate_dump #(
  parameter int WIDTH       = 16,
  parameter int LEN_WIDTH   = 8,
  parameter int SHIFT_WIDTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  input  logic [LEN_WIDTH-1:0]   i_len,
  input  logic [SHIFT_WIDTH-1:0] i_shift,
  input  logic [WIDTH-1:0]       i_in,
  input  logic                   i_strobe_in,
  output logic [WIDTH-1:0]       o_out,
  output logic                   o_strobe_out,
  output logic                   o_clipped
);

  localparam int ACC_WIDTH = WIDTH + LEN_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] C_MAX = ACC_WIDTH'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] C_MIN = ~C_MAX;

  logic signed [ACC_WIDTH-1:0] r_acc;
  logic [LEN_WIDTH-1:0]        r_count;
  logic [LEN_WIDTH-1:0]        r_len;
  logic [SHIFT_WIDTH-1:0]      r_shift;

  logic                        w_first;
  logic [LEN_WIDTH-1:0]        w_len_sel;
  logic [LEN_WIDTH-1:0]        w_len_eff;
  logic [SHIFT_WIDTH-1:0]      w_shift_cap;
  logic [SHIFT_WIDTH-1:0]      w_shift_sel;
  logic                        w_last;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic signed [ACC_WIDTH-1:0] w_shifted;
  logic                        w_clip_hi;
  logic                        w_clip_lo;
  logic [WIDTH-1:0]            w_out;

  // The first sample of a block must see the live settings, since they are only latched on that edge.
  assign w_first     = (r_count == '0);
  assign w_len_sel   = w_first ? i_len : r_len;
  assign w_len_eff   = (w_len_sel == '0) ? LEN_WIDTH'(1) : w_len_sel;
  assign w_shift_cap = (int'(i_shift) > LEN_WIDTH) ? SHIFT_WIDTH'(LEN_WIDTH) : i_shift;
  assign w_shift_sel = w_first ? w_shift_cap : r_shift;

  assign w_last    = (({1'b0, r_count} + (LEN_WIDTH + 1)'(1)) == {1'b0, w_len_eff});
  assign w_sum     = r_acc + $signed({{LEN_WIDTH{i_in[WIDTH-1]}}, i_in});
  assign w_shifted = w_sum >>> w_shift_sel;
  assign w_clip_hi = (w_shifted > C_MAX);
  assign w_clip_lo = (w_shifted < C_MIN);
  assign w_out     = w_clip_hi ? C_MAX[WIDTH-1:0] :
                     w_clip_lo ? C_MIN[WIDTH-1:0] : w_shifted[WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc        <= '0;
      r_count      <= '0;
      r_len        <= '0;
      r_shift      <= '0;
      o_out        <= '0;
      o_strobe_out <= 1'b0;
      o_clipped    <= 1'b0;
    end else if (i_clear) begin
      r_acc        <= '0;
      r_count      <= '0;
      o_strobe_out <= 1'b0;
      o_clipped    <= 1'b0;
    end else if (i_strobe_in) begin
      if (w_first) begin
        r_len   <= i_len;
        r_shift <= w_shift_cap;
      end
      if (w_last) begin
        r_acc        <= '0;
        r_count      <= '0;
        o_out        <= w_out;
        o_strobe_out <= 1'b1;
        o_clipped    <= w_clip_hi | w_clip_lo;
      end else begin
        r_acc        <= w_sum;
        r_count      <= r_count + LEN_WIDTH'(1);
        o_strobe_out <= 1'b0;
        o_clipped    <= 1'b0;
      end
    end else begin
      o_strobe_out <= 1'b0;
      o_clipped    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_strobed_integrate_dump.sv
// Directed bench for strobed_integrate_dump with hand-computed block sums.
module tb_strobed_integrate_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [7:0]  len;
  logic [3:0]  shift;
  logic [15:0] in_dat;
  logic        strobe_in;
  logic [15:0] out_dat;
  logic        strobe_out;
  logic        clipped;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  strobed_integrate_dump #(.WIDTH(16), .LEN_WIDTH(8), .SHIFT_WIDTH(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clear     (clear),
    .i_len       (len),
    .i_shift     (shift),
    .i_in        (in_dat),
    .i_strobe_in (strobe_in),
    .o_out       (out_dat),
    .o_strobe_out(strobe_out),
    .o_clipped   (clipped)
  );

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One clock with the given strobe/sample; checks the strobe seen just after the edge.
  task automatic step(input string tag, input logic stb, input int v, input logic exp_stb);
    strobe_in = stb;
    in_dat    = 16'(v);
    @(posedge clk);
    #1;
    check({tag, "_stb"}, {31'd0, strobe_out}, {31'd0, exp_stb});
    strobe_in = 1'b0;
  endtask

  task automatic check_dump(input string tag, input int exp_out, input logic exp_clip);
    check({tag, "_out"}, $signed(out_dat), exp_out);
    check({tag, "_clip"}, {31'd0, clipped}, {31'd0, exp_clip});
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; len = 8'd0; shift = 4'd0; in_dat = 16'd0; strobe_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", $signed(out_dat), 0);
    check("rst_stb", {31'd0, strobe_out}, 0);
    check("rst_clip", {31'd0, clipped}, 0);
    rst = 1'b0;

    // Basic block: (100+200+300+400) >>> 2 = 250
    len = 8'd4; shift = 4'd2;
    step("basic0", 1'b1, 100, 1'b0);
    step("basic1", 1'b1, 200, 1'b0);
    step("basic2", 1'b1, 300, 1'b0);
    step("basic3", 1'b1, 400, 1'b1);
    check_dump("basic", 250, 1'b0);
    step("basic_idle", 1'b0, 0, 1'b0);
    check("basic_hold", $signed(out_dat), 250);

    // len=0 acts as 1: every strobe dumps
    len = 8'd0; shift = 4'd0;
    for (int i = 0; i < 3; i++) begin
      step("pass", 1'b1, -5, 1'b1);
      check_dump("pass", -5, 1'b0);
    end
    // (-1 + -2) >>> 1 = floor(-1.5) = -2
    len = 8'd2; shift = 4'd1;
    step("neg0", 1'b1, -1, 1'b0);
    step("neg1", 1'b1, -2, 1'b1);
    check_dump("neg", -2, 1'b0);

    // Saturation both directions
    len = 8'd3; shift = 4'd0;
    step("satp0", 1'b1, 32767, 1'b0);
    step("satp1", 1'b1, 32767, 1'b0);
    step("satp2", 1'b1, 32767, 1'b1);
    check_dump("satp", 32767, 1'b1);
    step("satn0", 1'b1, -32768, 1'b0);
    check("satn0_clip", {31'd0, clipped}, 0);
    step("satn1", 1'b1, -32768, 1'b0);
    step("satn2", 1'b1, -32768, 1'b1);
    check_dump("satn", -32768, 1'b1);

    // Settings latched at block start; gaps inside a block hold state
    len = 8'd3; shift = 4'd0;
    step("lat0", 1'b1, 10, 1'b0);
    len = 8'd1; shift = 4'd3;
    step("lat1", 1'b1, 20, 1'b0);
    for (int i = 0; i < 5; i++) step("lat_gap", 1'b0, 0, 1'b0);
    step("lat2", 1'b1, 30, 1'b1);
    check_dump("lat", 60, 1'b0);
    step("lat_next", 1'b1, 16, 1'b1);
    check_dump("lat_next", 2, 1'b0);

    // Shift above LEN_WIDTH is treated as 8: -32768 >>> 8 = -128
    len = 8'd1; shift = 4'd15;
    step("shcap", 1'b1, -32768, 1'b1);
    check_dump("shcap", -128, 1'b0);

    // Clear mid-block drops the coincident sample and the partial sum
    len = 8'd4; shift = 4'd0;
    step("clr0", 1'b1, 1, 1'b0);
    step("clr1", 1'b1, 1, 1'b0);
    clear = 1'b1;
    step("clr2", 1'b1, 1, 1'b0);
    clear = 1'b0;
    check("clr_hold", $signed(out_dat), -128);
    for (int i = 0; i < 3; i++) step("clr_blk", 1'b1, 1, 1'b0);
    step("clr_blk3", 1'b1, 1, 1'b1);
    check_dump("clr_blk", 4, 1'b0);

    // Reset mid-block
    for (int i = 0; i < 3; i++) step("rstm", 1'b1, 1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rstm_out", $signed(out_dat), 0);
    check("rstm_stb", {31'd0, strobe_out}, 0);
    check("rstm_clip", {31'd0, clipped}, 0);
    for (int i = 0; i < 3; i++) step("rstm_blk", 1'b1, 1, 1'b0);
    step("rstm_blk3", 1'b1, 1, 1'b1);
    check_dump("rstm_blk", 4, 1'b0);
    step("end_idle", 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/strobed_integrate_dump.md
# strobed_integrate_dump

Downstream consumer of the registered saturating adder's `sum`/`strobe_out` stream. It accumulates a programmable number of strobed signed samples, then dumps the block sum. The dump is arithmetically right-shifted and clipped to `WIDTH` bits, and is emitted with a single-cycle output strobe. The block is used as the decimating integrate-and-dump stage in the same strobe-qualified datapath.

## Interface
- `WIDTH`, 16, sample and output width (signed two's complement)
- `LEN_WIDTH`, 8, width of `len`; maximum block length is 2^LEN_WIDTH-1 samples
- `SHIFT_WIDTH`, 4, width of `shift`
- `clk`  in  1  clock
- `rst`  in  1  reset: synchronous, active-high
- `clear`  in  1  synchronous restart; discards the partial block
- `len`  in  LEN_WIDTH  samples per block (unsigned); 0 treated as 1
- `shift`  in  SHIFT_WIDTH  output arithmetic right shift; values > LEN_WIDTH treated as LEN_WIDTH
- `in`  in  WIDTH  signed input sample
- `strobe_in`  in  1  `in` valid this cycle
- `out`  out  WIDTH  clipped, shifted block sum (registered)
- `strobe_out`  out  1  one-cycle pulse, `out` valid
- `clipped`  out  1  high with `strobe_out` when that dump saturated

## Operation
- **Internal state**
  - `acc`: signed, ACC_WIDTH = WIDTH+LEN_WIDTH bits; cannot overflow for any legal `len`.
  - `count`: LEN_WIDTH bits, samples accepted in the current block.
  - `len_r`, `shift_r`: per-block latched settings.
- **Block start**
  - `len` and `shift` are captured into `len_r`/`shift_r` on the `strobe_in` that arrives while `count`==0.
  - Changes to `len`/`shift` mid-block have no effect until the next block.
  - Effective length L = max(len_r,1). For the first sample the freshly captured value is used.
- **Accepted sample, not last** (count+1 < L): `acc <= acc + in`, `count <= count+1`.
- **Accepted sample, last** (count+1 == L):
  - Form s = (acc + in) >>> shift_r, arithmetic shift, truncation toward -inf.
  - `out <= clip(s)` to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - `clipped <= (s != clip(s))`, `strobe_out <= 1`.
  - `acc <= 0`, `count <= 0`.
- **No strobe**: `acc`/`count` hold; `strobe_out <= 0`, `clipped <= 0`; `out` holds its last value.
- **`clear`**
  - `acc <= 0`, `count <= 0`, `strobe_out <= 0`, `clipped <= 0`.
  - `clear` has priority over a coincident `strobe_in`; that sample is dropped.
  - `out` is held.
- **`rst`**: overrides everything. `acc`, `count`, `len_r`, `shift_r`, `out`, `strobe_out` and `clipped` all go to 0.
- **Mid-block reset or clear**: the partial block is lost with no dump. The next accepted sample starts a fresh block and recaptures `len`/`shift`.

## Timing
- Latency: `out`/`strobe_out`/`clipped` update on the clock edge that samples the last `strobe_in` of a block. They are visible in the following cycle.
- `strobe_out` is exactly one cycle wide. With L=1 and `strobe_in` held high, it is high every cycle.
- Full throughput: `strobe_in` may be asserted every cycle with no bubbles, including across block boundaries.
- No backpressure exists; the consumer must accept every `strobe_out`.
- Gaps of any length between strobes within a block are allowed; the state holds across them.
- Reset values after `rst`: `out`=0, `strobe_out`=0, `clipped`=0.

## Test plan
- **Basic block**: rst, then `len`=4, `shift`=2, strobed `in`=100,200,300,400 back-to-back → one `strobe_out` pulse the cycle after the 4th strobe, `out`=250, `clipped`=0; no other pulses.
- **Pass-through and negative truncation**: `len`=0, `shift`=0, strobed `in`=-5 every cycle for 3 cycles → 3 consecutive `strobe_out`, each `out`=-5. Then `len`=2, `shift`=1, `in`=-1,-2 → `out`=-2 (floor of -1.5).
- **Saturation**: `len`=3, `shift`=0, `in`=32767 ×3 → `out`=32767, `clipped`=1. Then `in`=-32768 ×3 → `out`=-32768, `clipped`=1.
- **Latched settings and gaps**:
  - Start a block with `len`=3, `shift`=0 using `in`=10.
  - Change to `len`=1, `shift`=3 mid-block.
  - Send `in`=20 and `in`=30 with 5 idle cycles between them.
  - Required: a single dump with `out`=60. The next single strobe with `in`=16 dumps `out`=2.
- **Clear and reset mid-block**:
  - `len`=4, feed 2 samples, assert `clear` coincident with a third `strobe_in` → no pulse; the next 4 samples of 1 give `out`=4.
  - Repeat with `rst` after 3 samples → all outputs 0, and the next full block of 4 samples of 1 gives `out`=4.
